mult_operand_sequencer: RTL and testbench

Upstream front end for the repeated-addition multiplier (data path plus control path). It accepts an operand pair over a valid/ready handshake and runs the multiplier's start/load protocol on its shared 16-bit data bus. It then waits for done, captures the product and returns it over a valid/ready result handshake. Zero operands are short-circuited, and a watchdog flags a multiplier that never finishes.

---
 rtl/mult_operand_sequencer_if.sv | 31 +++
 rtl/mult_operand_sequencer.sv | 133 +++++++++++++
 tb/tb_mult_operand_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_operand_sequencer_if.sv
// Handshake and multiplier-bus bundle for mult_operand_sequencer.
//   in_*   : operand pair valid/ready channel (producer -> sequencer)
//   mul_*  : start/data strobes to the multiplier, done/product back
//   out_*  : result valid/ready channel (sequencer -> consumer)
// master = environment side (producer, multiplier, consumer); slave = sequencer.
interface mult_operand_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             mul_start;
    logic [WIDTH-1:0] mul_data;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_product;
    logic             out_error;

    modport master (
        output in_valid, in_a, in_b, mul_done, mul_product, out_ready,
        input  in_ready, mul_start, mul_data, out_valid, out_product, out_error
    );

    modport slave (
        input  in_valid, in_a, in_b, mul_done, mul_product, out_ready,
        output in_ready, mul_start, mul_data, out_valid, out_product, out_error
    );
endinterface

// File: rtl/mult_operand_sequencer.sv
// Front end for the repeated-addition multiplier: accepts an operand pair,
// drives the start/load protocol on the shared data bus, waits for done
// (with a watchdog) and returns the product over a result handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mult_operand_sequencer_if.slave (operand, multiplier, result)
module mult_operand_sequencer #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 70000
) (
    input  logic                      clk,
    input  logic                      rst,
    mult_operand_sequencer_if.slave   bus
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE, START, LOAD_A, LOAD_B, WAIT, OUT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             mul_start_q, mul_start_d;
    logic [WIDTH-1:0] mul_data_q, mul_data_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_product_q, out_product_d;
    logic             out_error_q, out_error_d;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            in_ready_q    <= 1'b0;
            mul_start_q   <= 1'b0;
            mul_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cnt_q         <= cnt_d;
            in_ready_q    <= in_ready_d;
            mul_start_q   <= mul_start_d;
            mul_data_q    <= mul_data_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            out_error_q   <= out_error_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        cnt_d         = cnt_q;
        out_product_d = out_product_q;
        out_error_d   = out_error_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d = bus.in_a;
                    b_d = bus.in_b;
                    if ((bus.in_a == '0) || (bus.in_b == '0)) begin
                        state_d       = OUT;
                        out_product_d = '0;
                        out_error_d   = 1'b0;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START:  state_d = LOAD_A;
            LOAD_A: state_d = LOAD_B;
            LOAD_B: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (bus.mul_done) begin
                    state_d       = OUT;
                    out_product_d = bus.mul_product;
                    out_error_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = OUT;
                    out_product_d = '0;
                    out_error_d   = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OUT: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes follow the state being entered so they line up with it
        in_ready_d  = (state_d == IDLE);
        mul_start_d = (state_d == START) || (state_d == LOAD_A);
        unique case (state_d)
            LOAD_A:  mul_data_d = a_q;
            LOAD_B:  mul_data_d = b_q;
            default: mul_data_d = '0;
        endcase

        // Result valid rises one cycle into OUT and drops on the handshake edge
        out_valid_d = (state_q == OUT) && !(out_valid_q && bus.out_ready);
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.mul_start   = mul_start_q;
    assign bus.mul_data    = mul_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = out_product_q;
    assign bus.out_error   = out_error_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Bench for mult_operand_sequencer: directed plus random operand pairs, with
// an ideal multiplier model per DUT and a product/latency reference.
module tb_mult_operand_sequencer;

    localparam int unsigned W      = 16;
    localparam int          BUDGET = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_operand_sequencer_if #(.WIDTH(W)) ifa ();
    mult_operand_sequencer_if #(.WIDTH(W)) ifb ();

    mult_operand_sequencer #(.WIDTH(W)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    mult_operand_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(20)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    // Ideal multiplier for dut_a: loads A on the 2nd start cycle, B after, done ~B cycles later
    logic         pa_start;
    logic [W-1:0] ma_a, ma_b;
    int           ma_cnt;
    bit           ma_busy;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pa_start <= 1'b0; ma_busy <= 1'b0; ma_cnt <= 0; ma_a <= '0; ma_b <= '0;
            ifa.mul_done <= 1'b0; ifa.mul_product <= '0;
        end else begin
            pa_start <= ifa.mul_start;
            if (ifa.mul_start) ifa.mul_done <= 1'b0;
            if (pa_start && ifa.mul_start) ma_a <= ifa.mul_data;
            if (pa_start && !ifa.mul_start) begin
                ma_b <= ifa.mul_data; ma_cnt <= int'(ifa.mul_data); ma_busy <= 1'b1;
            end else if (ma_busy) begin
                if (ma_cnt <= 1) begin
                    ma_busy <= 1'b0; ifa.mul_done <= 1'b1; ifa.mul_product <= W'(ma_a * ma_b);
                end else ma_cnt <= ma_cnt - 1;
            end
        end
    end

    // Same model for dut_b, with a switch that makes done stick at 0
    bit           stuck_b;
    logic         pb_start;
    logic [W-1:0] mb_a, mb_b;
    int           mb_cnt;
    bit           mb_busy;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pb_start <= 1'b0; mb_busy <= 1'b0; mb_cnt <= 0; mb_a <= '0; mb_b <= '0;
            ifb.mul_done <= 1'b0; ifb.mul_product <= '0;
        end else begin
            pb_start <= ifb.mul_start;
            if (ifb.mul_start) ifb.mul_done <= 1'b0;
            if (pb_start && ifb.mul_start) mb_a <= ifb.mul_data;
            if (pb_start && !ifb.mul_start) begin
                mb_b <= ifb.mul_data; mb_cnt <= int'(ifb.mul_data); mb_busy <= 1'b1;
            end else if (mb_busy) begin
                if (mb_cnt <= 1) begin
                    mb_busy <= 1'b0;
                    if (!stuck_b) begin
                        ifb.mul_done <= 1'b1; ifb.mul_product <= W'(mb_a * mb_b);
                    end
                end else mb_cnt <= mb_cnt - 1;
            end
        end
    end

    int start_cnt = 0;
    always @(negedge clk) if (ifa.mul_start) start_cnt <= start_cnt + 1;

    int vectors    = 0;
    int miscompares = 0;

    logic         s_ov, s_err, s_ir, s_start, s_done;
    logic [W-1:0] s_prod, s_data;
    logic [W-1:0] dh [4];
    logic         sh [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap(input bit sel);
        if (sel) begin
            s_ov = ifb.out_valid; s_err = ifb.out_error; s_ir = ifb.in_ready;
            s_start = ifb.mul_start; s_done = ifb.mul_done; s_prod = ifb.out_product; s_data = ifb.mul_data;
        end else begin
            s_ov = ifa.out_valid; s_err = ifa.out_error; s_ir = ifa.in_ready;
            s_start = ifa.mul_start; s_done = ifa.mul_done; s_prod = ifa.out_product; s_data = ifa.mul_data;
        end
    endtask

    task automatic drive_in(input bit sel, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        if (sel) begin ifb.in_valid = v; ifb.in_a = a; ifb.in_b = b; end
        else     begin ifa.in_valid = v; ifa.in_a = a; ifa.in_b = b; end
    endtask

    task automatic drive_rdy(input bit sel, input logic r);
        if (sel) ifb.out_ready = r; else ifa.out_ready = r;
    endtask

    // Offer a pair; returns just after the accepting edge
    task automatic send(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk); snap(sel);
        while (!s_ir && n < 50) begin @(negedge clk); snap(sel); n++; end
        chk("in_ready_before_send", 64'(s_ir), 64'(1));
        drive_in(sel, 1'b1, a, b);
        @(posedge clk); #1;
        drive_in(sel, 1'b0, W'($urandom), W'($urandom));
    endtask

    // Wait for the result; exp_idx<0 means "two samples after done is first seen"
    task automatic get_result(input bit sel, input logic [W-1:0] exp_p, input logic exp_e,
                              input int exp_idx, input int hold, input string tag);
        int idx = 0;
        int done_idx = -1;
        for (int i = 0; i < 4; i++) begin dh[i] = 'x; sh[i] = 1'bx; end
        @(negedge clk); snap(sel);
        while (!s_ov && idx < BUDGET) begin
            if (idx < 4) begin dh[idx] = s_data; sh[idx] = s_start; end
            if (s_done && idx >= 3 && done_idx < 0) done_idx = idx;
            @(negedge clk); snap(sel); idx++;
        end
        chk({tag, "_valid"}, 64'(s_ov), 64'(1));
        chk({tag, "_latency"}, 64'(idx), (exp_idx >= 0) ? 64'(exp_idx) : 64'(done_idx + 2));
        chk({tag, "_product"}, 64'(s_prod), 64'(exp_p));
        chk({tag, "_error"}, 64'(s_err), 64'(exp_e));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); snap(sel);
            chk({tag, "_hold"}, {s_ov, s_ir, s_err, s_prod}, {1'b1, 1'b0, exp_e, exp_p});
        end
        drive_rdy(sel, 1'b1);
        @(posedge clk); #1;
        drive_rdy(sel, 1'b0);
        @(negedge clk); snap(sel);
        chk({tag, "_after_ack"}, {s_ov, s_ir}, 2'b01);
    endtask

    task automatic chk_reset_vals(input string tag);
        snap(0);
        chk(tag, {s_ov, s_ir, s_start, s_err, s_data, s_prod}, '0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rexp;
        int sc0;
        rst = 1'b1; stuck_b = 1'b0;
        drive_in(0, 1'b0, '0, '0); drive_in(1, 1'b0, '0, '0);
        drive_rdy(0, 1'b0); drive_rdy(1, 1'b0);
        #1 chk_reset_vals("reset_values");
        @(negedge clk); rst = 1'b0;
        #1 snap(0); chk("in_ready_before_first_edge", 64'(s_ir), 64'(0));
        @(posedge clk); #1 snap(0); chk("in_ready_after_release", 64'(s_ir), 64'(1));

        // 7 x 16 with bus sequence check
        send(0, 16'd7, 16'd16);
        get_result(0, 16'd112, 1'b0, -1, 0, "a7b16");
        chk("a7b16_bus", {dh[0], dh[1], dh[2], dh[3]}, {16'd0, 16'd7, 16'd16, 16'd0});
        chk("a7b16_start", 64'({sh[0], sh[1], sh[2], sh[3]}), 64'(4'b1100));

        // Zero short-circuit: result one edge after accept, multiplier untouched
        sc0 = start_cnt;
        send(0, 16'd0, 16'd9);
        get_result(0, 16'd0, 1'b0, 1, 0, "a0b9");
        send(0, 16'd5, 16'd0);
        get_result(0, 16'd0, 1'b0, 1, 0, "a5b0");
        chk("zero_no_start", 64'(start_cnt), 64'(sc0));

        // Truncated product
        send(0, 16'd300, 16'd300);
        get_result(0, 16'd24464, 1'b0, -1, 0, "a300b300");

        // Watchdog on the short-timeout instance, then recovery
        stuck_b = 1'b1;
        send(1, 16'd1234, 16'd5);
        get_result(1, 16'd0, 1'b1, 24, 0, "timeout");
        stuck_b = 1'b0;
        send(1, 16'd3, 16'd4);
        get_result(1, 16'd12, 1'b0, -1, 0, "after_timeout");

        // Held result, then back-to-back pairs
        send(0, 16'd2, 16'd3);
        get_result(0, 16'd6, 1'b0, -1, 10, "hold_2x3");
        send(0, 16'd4, 16'd5);
        get_result(0, 16'd20, 1'b0, -1, 0, "b2b_4x5");

        // Abort during WAIT
        send(0, 16'd9, 16'd100);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1 chk_reset_vals("abort_reset_values");
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1 snap(0); chk("abort_in_ready_low", {s_ov, s_ir}, 2'b00);
        @(posedge clk); #1 snap(0); chk("abort_in_ready_back", {s_ov, s_ir}, 2'b01);
        send(0, 16'd6, 16'd7);
        get_result(0, 16'd42, 1'b0, -1, 0, "after_abort_6x7");

        // Random pairs against the arithmetic reference
        for (int k = 0; k < 24; k++) begin
            ra = W'($urandom);
            rb = W'($urandom_range(0, 40));
            if ($urandom_range(0, 4) == 0) ra = '0;
            rexp = W'((32'(ra) * 32'(rb)) % 32'h10000);
            send(0, ra, rb);
            get_result(0, rexp, 1'b0, (ra == '0 || rb == '0) ? 1 : -1,
                       int'($urandom_range(0, 2)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
